psp_checker: RTL and testbench

- Serial pseudo-random sequence checker, directly downstream of the psp_reg_1 LFSR generator.
- Consumes the generator's 1-bit stream, self-synchronises a local LFSR to it, then free-runs and flags every mismatching bit.
- Reports lock status, a per-bit error pulse and a saturating error count for the lab bit-error-rate bench.

---
 rtl/psp_checker.sv | 129 ++++++++++++
 tb/tb_psp_checker.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psp_checker.sv
// Self-synchronising serial PRBS checker: seeds a local LFSR from the received stream,
// verifies it, then free-runs and flags every mismatching bit with a saturating count.
module psp_checker #(
  parameter int unsigned      WIDTH    = 7,
  parameter logic [WIDTH-1:0] POLY     = 7'h60,
  parameter int unsigned      LOCK_CNT = 16,
  parameter int unsigned      LOSS_CNT = 4,
  parameter int unsigned      CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_bit,
  input  logic             in_valid,
  input  logic             clr,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int unsigned FillW  = $clog2(WIDTH + 1);
  localparam int unsigned MatchW = $clog2(LOCK_CNT + 1);
  localparam int unsigned LossW  = $clog2(LOSS_CNT + 1);

  localparam logic [FillW-1:0]  FillLast  = FillW'(WIDTH - 1);
  localparam logic [MatchW-1:0] MatchLast = MatchW'(LOCK_CNT - 1);
  localparam logic [LossW-1:0]  LossLast  = LossW'(LOSS_CNT - 1);

  typedef enum logic [1:0] {StSeed, StVerify, StLocked} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   s_q, s_d;
  logic [FillW-1:0]   fill_q, fill_d;
  logic [MatchW-1:0]  match_q, match_d;
  logic [LossW-1:0]   run_q, run_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pred;

  assign pred = ^(s_q & POLY);

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    fill_d  = fill_q;
    match_d = match_q;
    run_d   = run_q;
    err_d   = 1'b0;
    if (in_valid) begin
      unique case (state_q)
        StSeed: begin
          s_d    = {s_q[WIDTH-2:0], in_bit};
          fill_d = fill_q + FillW'(1);
          if (fill_q == FillLast) begin
            state_d = StVerify;
            fill_d  = '0;
            match_d = '0;
          end
        end
        StVerify: begin
          // Verification trains on the received bit, not the prediction.
          s_d = {s_q[WIDTH-2:0], in_bit};
          if (s_q == '0) begin
            state_d = StSeed;
            fill_d  = '0;
          end else if (in_bit == pred) begin
            match_d = match_q + MatchW'(1);
            if (match_q == MatchLast) begin
              state_d = StLocked;
              run_d   = '0;
            end
          end else begin
            state_d = StSeed;
            fill_d  = '0;
          end
        end
        StLocked: begin
          // Free-run so an isolated flipped bit costs exactly one error.
          s_d = {s_q[WIDTH-2:0], pred};
          if (in_bit != pred) begin
            err_d = 1'b1;
            run_d = run_q + LossW'(1);
            if (run_q == LossLast) begin
              state_d = StSeed;
              fill_d  = '0;
              run_d   = '0;
            end
          end else begin
            run_d = '0;
          end
        end
        default: state_d = StSeed;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = CNT_W'(err_d);
    end else if (err_d && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StSeed;
      s_q     <= '0;
      fill_q  <= '0;
      match_q <= '0;
      run_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      run_q   <= run_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign locked  = (state_q == StLocked);
  assign err     = err_q;
  assign err_cnt = cnt_q;

endmodule

// File: tb/tb_psp_checker.sv
// Bench for psp_checker: directed scenarios plus a randomized run against a behavioural model.
module tb_psp_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_bit = 1'b0;
  logic        in_valid = 1'b0;
  logic        clr = 1'b0;
  logic        locked, err, locked2, err2;
  logic [15:0] err_cnt;
  logic [1:0]  err_cnt2;

  int total = 0;
  int bad = 0;
  logic [6:0] g;

  // Behavioural model state: 0 seed, 1 verify, 2 locked.
  int   m_mode, m_fill, m_match, m_run, m_cnt, m_cnt2;
  logic m_err;
  logic m_h[$];

  always #5 clk = ~clk;

  psp_checker dut (
    .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid), .clr(clr),
    .locked(locked), .err(err), .err_cnt(err_cnt)
  );

  psp_checker #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid), .clr(clr),
    .locked(locked2), .err(err2), .err_cnt(err_cnt2)
  );

  // PRBS7 source, x^7+x^6+1: b[n] = b[n-7] ^ b[n-6].
  task automatic next_bit(output logic b);
    b = g[6] ^ g[5];
    g = {g[5:0], b};
  endtask

  task automatic drive(input logic b, input logic v, input logic c);
    in_bit = b;
    in_valid = v;
    clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic restart(input logic [6:0] seed);
    in_valid = 1'b0;
    clr = 1'b0;
    rst = 1'b0;
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    g = seed;
  endtask

  task automatic feed_clean(input int n);
    logic b;
    for (int i = 0; i < n; i++) begin
      next_bit(b);
      drive(b, 1'b1, 1'b0);
    end
  endtask

  task automatic test_reset();
    #1;
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL reset_locked: got %b want 0", locked); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err); end
    total++; if (err_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", err_cnt); end
  endtask

  task automatic test_clean_lock();
    logic b;
    restart(7'h01);
    for (int i = 1; i <= 23; i++) begin
      next_bit(b);
      drive(b, 1'b1, 1'b0);
      total++;
      if (locked !== (i == 23)) begin
        bad++; $display("FAIL lock_latency bit %0d: got %b want %b", i, locked, (i == 23));
      end
    end
    for (int i = 0; i < 254; i++) begin
      next_bit(b);
      drive(b, 1'b1, 1'b0);
      total++; if (err !== 1'b0) begin bad++; $display("FAIL clean_err bit %0d: got %b want 0", i, err); end
    end
    total++; if (err_cnt !== 16'd0) begin bad++; $display("FAIL clean_cnt: got %0d want 0", err_cnt); end
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL clean_locked: got %b want 1", locked); end
  endtask

  task automatic test_flip();
    logic b, f;
    restart(7'h55);
    feed_clean(23);
    for (int n = 24; n <= 120; n++) begin
      next_bit(b);
      f = (n == 40) || (n == 100) || (n == 101);
      drive(b ^ f, 1'b1, 1'b0);
      total++; if (err !== f) begin bad++; $display("FAIL flip_err bit %0d: got %b want %b", n, err, f); end
      total++; if (locked !== 1'b1) begin bad++; $display("FAIL flip_locked bit %0d: got %b want 1", n, locked); end
    end
    total++; if (err_cnt !== 16'd3) begin bad++; $display("FAIL flip_cnt: got %0d want 3", err_cnt); end
  endtask

  task automatic test_saturate();
    logic b, f;
    restart(7'h13);
    feed_clean(23);
    for (int n = 24; n <= 80; n++) begin
      next_bit(b);
      f = (n % 10 == 0) && (n >= 30) && (n <= 70);
      drive(b ^ f, 1'b1, 1'b0);
    end
    total++; if (err_cnt !== 16'd5) begin bad++; $display("FAIL sat_cnt16: got %0d want 5", err_cnt); end
    total++; if (err_cnt2 !== 2'd3) begin bad++; $display("FAIL sat_cnt2: got %0d want 3", err_cnt2); end
  endtask

  task automatic test_invert();
    logic b;
    restart(7'h2a);
    feed_clean(30);
    for (int k = 1; k <= 4; k++) begin
      next_bit(b);
      drive(~b, 1'b1, 1'b0);
      total++; if (err !== 1'b1) begin bad++; $display("FAIL inv_err %0d: got %b want 1", k, err); end
      total++;
      if (locked !== (k < 4)) begin
        bad++; $display("FAIL inv_locked %0d: got %b want %b", k, locked, (k < 4));
      end
    end
    total++; if (err_cnt !== 16'd4) begin bad++; $display("FAIL inv_cnt: got %0d want 4", err_cnt); end
    for (int i = 1; i <= 23; i++) begin
      next_bit(b);
      drive(b, 1'b1, 1'b0);
      total++;
      if (locked !== (i == 23)) begin
        bad++; $display("FAIL relock bit %0d: got %b want %b", i, locked, (i == 23));
      end
    end
  endtask

  task automatic test_zeros();
    logic seen;
    seen = 1'b0;
    restart(7'h01);
    for (int i = 0; i < 200; i++) begin
      drive(1'b0, 1'b1, 1'b0);
      if (locked === 1'b1) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL zero_lock: got %b want 0", seen); end
    total++; if (err_cnt !== 16'd0) begin bad++; $display("FAIL zero_cnt: got %0d want 0", err_cnt); end
  endtask

  task automatic test_alternate();
    logic b;
    int vc;
    vc = 0;
    restart(7'h40);
    for (int c = 1; c <= 46; c++) begin
      if (c % 2 == 1) begin
        next_bit(b);
        vc++;
        drive(b, 1'b1, 1'b0);
      end else begin
        drive(1'($urandom), 1'b0, 1'b0);
      end
      total++;
      if (locked !== (vc >= 23)) begin
        bad++; $display("FAIL alt_lock cycle %0d: got %b want %b", c, locked, (vc >= 23));
      end
    end
  endtask

  task automatic test_clr();
    logic b, f, c;
    restart(7'h33);
    feed_clean(23);
    for (int n = 24; n <= 46; n++) begin
      next_bit(b);
      f = (n == 30) || (n == 35) || (n == 40);
      c = (n == 40) || (n == 45);
      drive(b ^ f, 1'b1, c);
      if (n == 39) begin
        total++; if (err_cnt !== 16'd2) begin bad++; $display("FAIL clr_pre: got %0d want 2", err_cnt); end
      end
      if (n == 40) begin
        total++; if (err !== 1'b1) begin bad++; $display("FAIL clr_err: got %b want 1", err); end
        total++; if (err_cnt !== 16'd1) begin bad++; $display("FAIL clr_coinc: got %0d want 1", err_cnt); end
      end
    end
    total++; if (err_cnt !== 16'd0) begin bad++; $display("FAIL clr_only: got %0d want 0", err_cnt); end
  endtask

  task automatic test_async_reset();
    logic b;
    restart(7'h7f);
    feed_clean(30);
    next_bit(b);
    drive(~b, 1'b1, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL arst_locked: got %b want 0", locked); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL arst_err: got %b want 0", err); end
    total++; if (err_cnt !== 16'd0) begin bad++; $display("FAIL arst_cnt: got %0d want 0", err_cnt); end
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 1; i <= 23; i++) begin
      next_bit(b);
      drive(b, 1'b1, 1'b0);
      total++;
      if (locked !== (i == 23)) begin
        bad++; $display("FAIL arst_relock bit %0d: got %b want %b", i, locked, (i == 23));
      end
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_fill = 0; m_match = 0; m_run = 0; m_cnt = 0; m_cnt2 = 0; m_err = 1'b0;
    m_h.delete();
    for (int i = 0; i < 7; i++) m_h.push_back(1'b0);
  endtask

  task automatic model_push(input logic x);
    m_h.push_back(x);
    void'(m_h.pop_front());
  endtask

  task automatic model_step(input logic b, input logic v, input logic c);
    logic pred;
    int ones;
    m_err = 1'b0;
    pred = m_h[0] ^ m_h[1];
    ones = 0;
    foreach (m_h[i]) ones += int'(m_h[i]);
    if (v) begin
      if (m_mode == 0) begin
        model_push(b);
        m_fill++;
        if (m_fill == 7) begin m_mode = 1; m_fill = 0; m_match = 0; end
      end else if (m_mode == 1) begin
        model_push(b);
        if (ones == 0 || b != pred) begin
          m_mode = 0; m_fill = 0;
        end else begin
          m_match++;
          if (m_match == 16) begin m_mode = 2; m_run = 0; end
        end
      end else begin
        model_push(pred);
        if (b != pred) begin
          m_err = 1'b1;
          m_run++;
          if (m_run == 4) begin m_mode = 0; m_fill = 0; m_run = 0; end
        end else begin
          m_run = 0;
        end
      end
    end
    if (c) begin
      m_cnt = int'(m_err);
      m_cnt2 = int'(m_err);
    end else if (m_err) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt2 < 3) m_cnt2++;
    end
  endtask

  task automatic test_random();
    logic b, v, c;
    int inv_left;
    inv_left = 0;
    restart(7'($urandom_range(1, 127)));
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      v = ($urandom_range(0, 9) < 8);
      c = ($urandom_range(0, 29) == 0);
      if (v) begin
        next_bit(b);
        if (inv_left > 0) begin
          b = ~b;
          inv_left--;
        end else if ($urandom_range(0, 59) == 0) begin
          b = ~b;
        end else if ($urandom_range(0, 149) == 0) begin
          inv_left = $urandom_range(1, 6);
        end
      end else begin
        b = 1'($urandom);
      end
      drive(b, v, c);
      model_step(b, v, c);
      total++;
      if (locked !== (m_mode == 2)) begin
        bad++; $display("FAIL rnd_locked cyc %0d: got %b want %b", i, locked, (m_mode == 2));
      end
      total++; if (err !== m_err) begin bad++; $display("FAIL rnd_err cyc %0d: got %b want %b", i, err, m_err); end
      total++;
      if (err_cnt !== 16'(m_cnt)) begin
        bad++; $display("FAIL rnd_cnt cyc %0d: got %0d want %0d", i, err_cnt, m_cnt);
      end
      total++;
      if (err_cnt2 !== 2'(m_cnt2)) begin
        bad++; $display("FAIL rnd_cnt2 cyc %0d: got %0d want %0d", i, err_cnt2, m_cnt2);
      end
    end
  endtask

  initial begin
    g = 7'h01;
    test_reset();
    test_clean_lock();
    test_flip();
    test_saturate();
    test_invert();
    test_zeros();
    test_alternate();
    test_clr();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
